// File: rtl/div.sv
// Multi-cycle 32-bit divider for the EX stage: restoring shift-subtract, one quotient bit per clock.
// Result is {remainder, quotient}, held in END for as long as the requester keeps start_i high.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] pr_q, pr_d;
    logic [31:0] divisor_q, divisor_d;
    logic        sgn_q, sgn_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] abs1, abs2;
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [31:0] quo_fix, rem_fix;

    assign abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // pr_q holds {partial remainder, remaining dividend bits / quotient bits}
    assign shifted = {pr_q[63:0], 1'b0};
    assign trial   = shifted[64:32] - {1'b0, divisor_q};

    assign quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~pr_q[31:0] + 32'd1) : pr_q[31:0];
    assign rem_fix = (sgn_q && neg1_q) ? (~pr_q[63:32] + 32'd1) : pr_q[63:32];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pr_d      = pr_q;
        divisor_d = divisor_q;
        sgn_d     = sgn_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        ready_d   = 1'b0;
        result_d  = 64'h0;

        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'h0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = 6'd0;
                        pr_d      = {33'b0, abs1};
                        divisor_d = abs2;
                        sgn_d     = signed_div_i;
                        neg1_d    = opdata1_i[31];
                        neg2_d    = opdata2_i[31];
                    end
                end
            end
            BYZERO: begin
                if (annul_i) begin
                    state_d = FREE;
                end else begin
                    state_d = END;
                    pr_d    = 65'h0;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_d = FREE;
                    cnt_d   = 6'd0;
                    pr_d    = 65'h0;
                end else if (cnt_q == 6'd32) begin
                    state_d = END;
                    pr_d    = {1'b0, rem_fix, quo_fix};
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    // trial[32] set means the subtraction went negative: restore
                    pr_d  = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
                end
            end
            END: begin
                if (start_i) begin
                    ready_d  = 1'b1;
                    result_d = pr_q[63:0];
                end else begin
                    state_d = FREE;
                end
            end
            default: state_d = FREE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            pr_q      <= 65'h0;
            divisor_q <= 32'h0;
            sgn_q     <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pr_q      <= pr_d;
            divisor_q <= divisor_d;
            sgn_q     <= sgn_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
